arinc429_rx_decoder: RTL and testbench
======================================

ARINC429_RX_DECODER -- requirements
Module: arinc429_rx_decoder

Interface
REQ-001 SHALL have parameter GAP_W, default 16, meaning the width of the gap and pulse-width counters and of their threshold inputs.
REQ-002 SHALL have port clk, input, 1 bit: clock; all logic is on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port line_hi, input, 1 bit: filtered ARINC429 HI leg, already synchronous to clk.
REQ-005 SHALL have port line_lo, input, 1 bit: filtered ARINC429 LO leg, already synchronous to clk.
REQ-006 SHALL have port gap_cycles, input, GAP_W bits: consecutive NULL cycles that terminate a word; a value of 0 is treated as 1.
REQ-007 SHALL have port bit_max, input, GAP_W bits: maximum cycles of one HI/LO pulse; a value of 0 disables the check.
REQ-008 SHALL have port rx_word, output, 32 bits: the last decoded word.
REQ-009 SHALL have port rx_valid, output, 1 bit: one-cycle strobe, rx_word is new.
REQ-010 SHALL have port rx_parity_err, output, 1 bit: parity result, qualified by rx_valid.
REQ-011 SHALL have port rx_frame_err, output, 1 bit: one-cycle strobe, word discarded.
REQ-012 SHALL have port rx_busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-013 SHALL decode the line state as {line_hi,line_lo}: 00 = NULL, 10 = ONE, 01 = ZERO, 11 = INVALID.
REQ-014 SHALL register the previous line state and accept one bit on each cycle where previous = NULL and current = ONE or ZERO.
REQ-015 SHALL write the n-th accepted bit of a word (n = 1..32) to rx_word[n-1], holding it in a shift register.
REQ-016 SHALL implement states IDLE, RECV and WAIT_GAP.
REQ-017 IDLE SHALL go to RECV on an accepted bit, with bit count = 1.
REQ-018 IDLE SHALL go to WAIT_GAP with an rx_frame_err pulse on INVALID.
REQ-019 RECV SHALL increment the bit count on each accepted bit.
REQ-020 RECV SHALL run a NULL counter that clears on any non-NULL cycle and saturates at gap_cycles.
REQ-021 When the NULL counter reaches the effective gap with bit count = 32, RECV SHALL load rx_word and pulse rx_valid on the next cycle, then return to IDLE.
REQ-022 When the NULL counter reaches the effective gap with bit count of 1..31, RECV SHALL pulse rx_frame_err, return to IDLE and leave rx_word unchanged.
REQ-023 A 33rd accepted bit SHALL cause an rx_frame_err pulse on the next cycle and a transition to WAIT_GAP.
REQ-024 INVALID in RECV SHALL cause an rx_frame_err pulse and a transition to WAIT_GAP.
REQ-025 A continuous ONE or ZERO run exceeding bit_max cycles (bit_max ≠ 0) SHALL cause an rx_frame_err pulse and a transition to WAIT_GAP.
REQ-026 WAIT_GAP SHALL discard all bits and go to IDLE once gap_cycles consecutive NULL cycles are seen, with no strobe.
REQ-027 rx_parity_err SHALL equal 1 when the XOR of all 32 received bits is 0 (ARINC odd parity), and SHALL be updated only together with rx_valid.
REQ-028 rx_valid and rx_frame_err SHALL never be high in the same cycle.
REQ-029 All counters SHALL saturate and never wrap.
REQ-030 gap_cycles and bit_max changes SHALL take effect on the next cycle.

Reset
REQ-031 Asserting rst_n low SHALL immediately clear rx_word, rx_valid, rx_parity_err, rx_frame_err and rx_busy, and all counters and the shift register, to 0.
REQ-032 Reset SHALL set the state to IDLE and the previous line state to NULL.
REQ-033 Reset mid-word SHALL discard the partial word with no strobe.

Structure
REQ-034 Package arinc429_pkg SHALL hold the line-state enum (NULL/ONE/ZERO/INVALID), the decoder state enum (IDLE/RECV/WAIT_GAP) and the constant WORD_LEN = 32.
REQ-035 Sub-module arinc429_sat_cnt (GAP_W-bit clear/increment saturating counter) SHALL be instantiated twice: once for the NULL run and once for the pulse width.
REQ-036 All outputs SHALL be registered.

Verification
Common setup: gap_cycles = 40, bit_max = 20, each bit sent as 10 cycles HI/LO followed by 10 cycles NULL.
REQ-037 Send 0x00000001, then 40 NULL cycles -> rx_valid pulse once, rx_word = 0x00000001, rx_parity_err = 0.
REQ-038 Send 0x00000003 -> rx_valid pulse, rx_word = 0x00000003, rx_parity_err = 1.
REQ-039 Send 31 bits, then 40 NULL cycles -> one rx_frame_err pulse, no rx_valid, rx_word unchanged.
REQ-040 Send 33 bits with no gap -> rx_frame_err pulse after the 33rd bit; the next 32-bit word 0x80000000 -> rx_valid with that word.
REQ-041 Hold HI for 25 cycles in mid-word -> rx_frame_err pulse, rx_busy stays high until 40 NULL cycles have passed.
REQ-042 Set {hi,lo} = 11 in mid-word -> rx_frame_err pulse, then WAIT_GAP.
REQ-043 Assert rst_n at bit 16 -> all outputs 0 at once; the next full word 0x00000001 -> rx_valid.

Source files
------------

// File: rtl/arinc429_pkg.sv
// Shared types for the ARINC429 receive path: line-state decode, decoder FSM states, word length.
package arinc429_pkg;
    localparam int WORD_LEN = 32;

    typedef enum logic [1:0] {
        LS_NULL    = 2'b00,
        LS_ZERO    = 2'b01,
        LS_ONE     = 2'b10,
        LS_INVALID = 2'b11
    } line_state_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_RECV     = 2'b01,
        ST_WAIT_GAP = 2'b10
    } dec_state_e;
endpackage

// File: rtl/arinc429_sat_cnt.sv
// Clear/increment counter that stops at max_i instead of wrapping.
module arinc429_sat_cnt
    import arinc429_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    input  logic [W-1:0] max_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q < max_i)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/arinc429_rx_decoder.sv
// ARINC429 word receiver: accepts a bit on each NULL->ONE/ZERO edge, frames words on a NULL gap.
//
// state       | meaning
// ST_IDLE     | between words, waiting for the first bit
// ST_RECV     | collecting bits, watching for the terminating gap
// ST_WAIT_GAP | word discarded after an error, waiting for a clean gap
module arinc429_rx_decoder
    import arinc429_pkg::*;
#(
    parameter int GAP_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             line_hi,
    input  logic             line_lo,
    input  logic [GAP_W-1:0] gap_cycles,
    input  logic [GAP_W-1:0] bit_max,
    output logic [31:0]      rx_word,
    output logic             rx_valid,
    output logic             rx_parity_err,
    output logic             rx_frame_err,
    output logic             rx_busy
);
    localparam logic [5:0] LAST_BIT = 6'(WORD_LEN);

    line_state_e      line_cur, prev_q;
    dec_state_e       state_q, state_d;
    logic [5:0]       bit_cnt_q, bit_cnt_d;
    logic [31:0]      sr_q, sr_d, word_q, word_d;
    logic             valid_q, valid_d, par_q, par_d, ferr_q, ferr_d, busy_q;
    logic [GAP_W-1:0] gap_eff, null_cnt, pw_cnt;
    logic             is_null, is_data, accept, gap_done, pw_over, rx_bit;

    assign line_cur = line_state_e'({line_hi, line_lo});
    assign is_null  = (line_cur == LS_NULL);
    assign is_data  = (line_cur == LS_ONE) || (line_cur == LS_ZERO);
    assign accept   = (prev_q == LS_NULL) && is_data;
    assign rx_bit   = (line_cur == LS_ONE);
    assign gap_eff  = (gap_cycles == '0) ? GAP_W'(1) : gap_cycles;

    arinc429_sat_cnt #(.W(GAP_W)) u_null_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (!is_null),
        .inc_i (is_null),
        .max_i (gap_eff),
        .cnt_o (null_cnt)
    );

    // Counter holds (run length - 1); a new run starts on any change of line state.
    arinc429_sat_cnt #(.W(GAP_W)) u_pw_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (!is_data || (line_cur != prev_q)),
        .inc_i (1'b1),
        .max_i ('1),
        .cnt_o (pw_cnt)
    );

    // Both compares include the cycle currently on the line.
    assign gap_done = is_null && (null_cnt >= (gap_eff - GAP_W'(1)));
    assign pw_over  = (bit_max != '0) && is_data && (line_cur == prev_q)
                      && (pw_cnt >= (bit_max - GAP_W'(1)));

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sr_d      = sr_q;
        word_d    = word_q;
        par_d     = par_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (line_cur == LS_INVALID) begin
                    ferr_d  = 1'b1;
                    state_d = ST_WAIT_GAP;
                end else if (accept) begin
                    bit_cnt_d = 6'd1;
                    sr_d      = {rx_bit, sr_q[31:1]};
                    state_d   = ST_RECV;
                end
            end
            ST_RECV: begin
                if (line_cur == LS_INVALID || (accept && bit_cnt_q == LAST_BIT) || pw_over) begin
                    ferr_d    = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = ST_WAIT_GAP;
                end else if (accept) begin
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    sr_d      = {rx_bit, sr_q[31:1]};
                end else if (gap_done) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        word_d  = sr_q;
                        par_d   = ~(^sr_q);
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                    bit_cnt_d = '0;
                    state_d   = ST_IDLE;
                end
            end
            ST_WAIT_GAP: begin
                if (gap_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            prev_q    <= LS_NULL;
            bit_cnt_q <= '0;
            sr_q      <= '0;
            word_q    <= '0;
            par_q     <= 1'b0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= line_cur;
            bit_cnt_q <= bit_cnt_d;
            sr_q      <= sr_d;
            word_q    <= word_d;
            par_q     <= par_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            busy_q    <= (state_d != ST_IDLE);
        end
    end

    assign rx_word       = word_q;
    assign rx_valid      = valid_q;
    assign rx_parity_err = par_q;
    assign rx_frame_err  = ferr_q;
    assign rx_busy       = busy_q;
endmodule

// File: tb/tb_arinc429_rx_decoder.sv
// Bench for arinc429_rx_decoder: line segments drive both the DUT and a segment-level word model.
module tb_arinc429_rx_decoder;
    localparam logic [1:0] L_NULL = 2'b00, L_ZERO = 2'b01, L_ONE = 2'b10, L_INV = 2'b11;

    logic        clk = 1'b0, rst_n = 1'b1, line_hi = 1'b0, line_lo = 1'b0;
    logic [15:0] gap_cycles = 16'd40, bit_max = 16'd20;
    logic [31:0] rx_word;
    logic        rx_valid, rx_parity_err, rx_frame_err, rx_busy;

    always #5 clk = ~clk;

    arinc429_rx_decoder #(.GAP_W(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .line_hi       (line_hi),
        .line_lo       (line_lo),
        .gap_cycles    (gap_cycles),
        .bit_max       (bit_max),
        .rx_word       (rx_word),
        .rx_valid      (rx_valid),
        .rx_parity_err (rx_parity_err),
        .rx_frame_err  (rx_frame_err),
        .rx_busy       (rx_busy)
    );

    typedef struct {
        bit          ferr;
        logic [31:0] word;
        bit          par;
    } ev_t;

    ev_t dut_q[$];
    ev_t exp_q[$];
    int  n_cmp = 0, n_err = 0;
    int  pw_lo = 10, pw_hi = 10, nl_lo = 10, nl_hi = 10;

    // model state: mode 0 = between words, 1 = collecting, 2 = discarding until gap
    int          m_mode, m_nbits, m_null;
    logic [31:0] m_sr, m_word;
    bit          m_par, m_prev_null;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (rx_valid || rx_frame_err)) begin
            ev_t e;
            chk("valid_ferr_excl", {31'b0, rx_valid & rx_frame_err}, 32'd0);
            e.ferr = rx_frame_err;
            e.word = rx_word;
            e.par  = rx_parity_err;
            dut_q.push_back(e);
        end
    end

    function automatic int gap_eff();
        return (gap_cycles == 16'd0) ? 1 : int'(gap_cycles);
    endfunction

    task automatic push_exp(input bit ferr);
        ev_t e;
        e.ferr = ferr;
        e.word = m_word;
        e.par  = m_par;
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        m_mode = 0; m_nbits = 0; m_null = 0; m_sr = '0; m_word = '0;
        m_par = 1'b0; m_prev_null = 1'b1;
        exp_q.delete();
        dut_q.delete();
    endtask

    task automatic model_seg(input logic [1:0] lvl, input int len);
        if (lvl == L_NULL) begin
            m_null += len;
            m_prev_null = 1'b1;
            if (m_mode != 0 && m_null >= gap_eff()) begin
                if (m_mode == 1) begin
                    if (m_nbits == 32) begin
                        m_word = m_sr;
                        m_par  = ($countones(m_sr) % 2) == 0;
                        push_exp(1'b0);
                    end else begin
                        push_exp(1'b1);
                    end
                end
                m_mode = 0;
            end
        end else if (lvl == L_INV) begin
            m_null = 0;
            m_prev_null = 1'b0;
            if (m_mode != 2) begin
                push_exp(1'b1);
                m_mode = 2;
            end
        end else begin
            m_null = 0;
            if (m_prev_null) begin
                if (m_mode == 0) begin
                    m_mode = 1; m_nbits = 1; m_sr[0] = (lvl == L_ONE);
                end else if (m_mode == 1) begin
                    if (m_nbits == 32) begin
                        push_exp(1'b1);
                        m_mode = 2;
                    end else begin
                        m_sr[m_nbits] = (lvl == L_ONE);
                        m_nbits++;
                    end
                end
            end
            m_prev_null = 1'b0;
            if (m_mode == 1 && bit_max != 16'd0 && len > int'(bit_max)) begin
                push_exp(1'b1);
                m_mode = 2;
            end
        end
    endtask

    task automatic drive_seg(input logic [1:0] lvl, input int len);
        {line_hi, line_lo} = lvl;
        repeat (len) @(posedge clk);
        #1;
        model_seg(lvl, len);
    endtask

    task automatic send_bits(input logic [63:0] v, input int n, input int long_at,
                             input int long_w, input int inv_at);
        for (int i = 0; i < n; i++) begin
            drive_seg(v[i] ? L_ONE : L_ZERO,
                      (i == long_at) ? long_w : int'($urandom_range(pw_hi, pw_lo)));
            if (i == inv_at) drive_seg(L_INV, int'($urandom_range(5, 1)));
            drive_seg(L_NULL, int'($urandom_range(nl_hi, nl_lo)));
        end
    endtask

    task automatic cmp_events(input string tag);
        int n;
        chk({tag, "_count"}, dut_q.size(), exp_q.size());
        n = (dut_q.size() < exp_q.size()) ? dut_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_ev%0d_kind", tag, i), {31'b0, dut_q[i].ferr}, {31'b0, exp_q[i].ferr});
            chk($sformatf("%s_ev%0d_word", tag, i), dut_q[i].word, exp_q[i].word);
            chk($sformatf("%s_ev%0d_par", tag, i), {31'b0, dut_q[i].par}, {31'b0, exp_q[i].par});
        end
        dut_q.delete();
        exp_q.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_word"}, rx_word, 32'd0);
        chk({tag, "_valid"}, {31'b0, rx_valid}, 32'd0);
        chk({tag, "_par"}, {31'b0, rx_parity_err}, 32'd0);
        chk({tag, "_ferr"}, {31'b0, rx_frame_err}, 32'd0);
        chk({tag, "_busy"}, {31'b0, rx_busy}, 32'd0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 chk_all_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        drive_seg(L_NULL, 5);

        send_bits(64'h1, 32, -1, 0, -1);
        drive_seg(L_NULL, 40);
        cmp_events("word1");
        chk("word1_rx_word", rx_word, 32'h0000_0001);
        chk("word1_par", {31'b0, rx_parity_err}, 32'd0);

        send_bits(64'h3, 32, -1, 0, -1);
        drive_seg(L_NULL, 40);
        cmp_events("word3");
        chk("word3_rx_word", rx_word, 32'h0000_0003);
        chk("word3_par", {31'b0, rx_parity_err}, 32'd1);

        send_bits(64'hFFFF, 31, -1, 0, -1);
        drive_seg(L_NULL, 40);
        cmp_events("short31");
        chk("short31_word_kept", rx_word, 32'h0000_0003);

        send_bits(64'h1_2345_6789, 33, -1, 0, -1);
        drive_seg(L_NULL, 40);
        cmp_events("long33");
        send_bits(64'h8000_0000, 32, -1, 0, -1);
        drive_seg(L_NULL, 40);
        cmp_events("after33");
        chk("after33_word", rx_word, 32'h8000_0000);

        send_bits(64'h15, 6, 5, 25, -1);
        drive_seg(L_NULL, 20);
        chk("pulse_busy_hold", {31'b0, rx_busy}, 32'd1);
        drive_seg(L_NULL, 15);
        chk("pulse_busy_drop", {31'b0, rx_busy}, 32'd0);
        cmp_events("pulse25");

        send_bits(64'h2AA, 10, -1, 0, 9);
        chk("invalid_busy", {31'b0, rx_busy}, 32'd1);
        drive_seg(L_NULL, 40);
        cmp_events("invalid");

        send_bits(64'hA5A5_5A5A, 32, 3, 20, -1);
        drive_seg(L_NULL, 40);
        cmp_events("pulse_eq_max");
        send_bits(64'hA5A5_5A5A, 32, 3, 21, -1);
        drive_seg(L_NULL, 40);
        cmp_events("pulse_max_plus1");

        bit_max = 16'd0;
        send_bits(64'hDEAD_BEEF, 32, 7, 30, -1);
        drive_seg(L_NULL, 40);
        cmp_events("bitmax_off");
        bit_max = 16'd20;

        gap_cycles = 16'd0;
        send_bits(64'h1, 1, -1, 0, -1);
        drive_seg(L_NULL, 5);
        cmp_events("gap_zero");
        gap_cycles = 16'd40;

        send_bits(64'h1, 16, -1, 0, -1);
        cmp_events("pre_reset");
        rst_n = 1'b0;
        #1 chk_all_zero("mid_reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        drive_seg(L_NULL, 5);
        send_bits(64'h1, 32, -1, 0, -1);
        drive_seg(L_NULL, 40);
        cmp_events("post_reset");
        chk("post_reset_word", rx_word, 32'h0000_0001);

        pw_lo = 5; pw_hi = 15; nl_lo = 3; nl_hi = 15;
        for (int f = 0; f < 30; f++) begin
            logic [63:0] w;
            int          kind;
            w          = {$urandom, $urandom};
            gap_cycles = ($urandom_range(1, 0) != 0) ? 16'd40 : 16'd20;
            bit_max    = ($urandom_range(3, 0) == 0) ? 16'd0 : 16'd20;
            kind       = int'($urandom_range(5, 0));
            case (kind)
                2:       send_bits(w, int'($urandom_range(31, 1)), -1, 0, -1);
                3:       send_bits(w, 33, -1, 0, -1);
                4:       send_bits(w, 32, int'($urandom_range(31, 0)), int'($urandom_range(30, 21)), -1);
                5:       send_bits(w, 32, -1, 0, int'($urandom_range(30, 0)));
                default: send_bits(w, 32, -1, 0, -1);
            endcase
            drive_seg(L_NULL, gap_eff() + int'($urandom_range(10, 0)));
            cmp_events($sformatf("rnd%0d", f));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
